bios_loader: RTL

Boot-copy engine that reads the BIOS program out of the synchronous instruction ROM and writes it, word by word, into processor instruction memory. It drives the ROM's address port, consumes its registered data output (one-cycle read latency), and performs a ready-qualified write into instruction RAM. Copying stops after the `hlt` instruction word or after the ROM depth is exhausted. It sits between the BIOS ROM and the instruction-memory write port and releases the core once `done` rises.

---
 rtl/bios_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/bios_loader.sv
// Boot-copy engine: streams the BIOS image out of the synchronous ROM into
// instruction memory, stopping after the halt word or at the end of the ROM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | out of reset, waiting for start
// FETCH   | ROM samples romAddress on this edge
// CAPTURE | romData valid; register the write and decide if it is last
// WRITE   | memWrite held until memReady accepts the word
// DONE    | copy complete, done held until next start
module bios_loader #(
   parameter int          WORDS       = 64,
   parameter logic [31:0] MEM_BASE    = 32'd0,
   parameter logic [5:0]  HALT_OPCODE = 6'b011101,
   parameter bit          STOP_ON_HLT = 1'b1
) (
   input  logic        clk_auto,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] romAddress,
   input  logic [31:0] romData,
   output logic        memWrite,
   output logic [31:0] memAddress,
   output logic [31:0] memData,
   input  logic        memReady,
   output logic        busy,
   output logic        done,
   output logic [6:0]  wordCount
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [31:0] LAST_INDEX = 32'(WORDS - 1);

   state_t state;
   logic   last_word;

   always_ff @(posedge clk_auto) begin
      if (!reset) begin
         state      <= IDLE;
         romAddress <= 32'd0;
         memWrite   <= 1'b0;
         memAddress <= 32'd0;
         memData    <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wordCount  <= 7'd0;
         last_word  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  romAddress <= 32'd0;
                  wordCount  <= 7'd0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               memData    <= romData;
               memAddress <= MEM_BASE + romAddress;
               memWrite   <= 1'b1;
               // The end-of-ROM term keeps romAddress from ever passing WORDS-1.
               last_word  <= (STOP_ON_HLT && (romData[31:26] == HALT_OPCODE)) ||
                             (romAddress == LAST_INDEX);
               state      <= WRITE;
            end
            WRITE: begin
               if (memReady) begin
                  memWrite  <= 1'b0;
                  wordCount <= wordCount + 7'd1;
                  if (last_word) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     romAddress <= romAddress + 32'd1;
                     state      <= FETCH;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
